// File: rtl/alu_status_stage.sv
// Registered ALU output stage: captures result/opcode, derives {N,Z,C,V}, 2-entry skid buffer.
// Optional sticky-overflow flag built when ALU_STATUS_STICKY_EN is defined.
//
//  state | meaning
//  EMPTY | out register invalid, skid empty
//  ONE   | out register valid, skid empty
//  FULL  | out register valid, skid holds the next word (in_ready low)

module alu_status_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [3:0]   in_opcode,
    input  logic [N-1:0] in_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_opcode,
    output logic [3:0]   out_flags
`ifdef ALU_STATUS_STICKY_EN
    ,
    input  logic         clr_sticky,
    output logic         sticky_v
`endif
);

    localparam int W = N + 8;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;

    logic         accept;
    logic         consume;
    logic [N:0]   sum;
    logic         flag_n, flag_z, flag_c, flag_v;
    logic [W-1:0] in_word;

    // Flags are derived from the incoming word and travel with it through the buffer.
    always_comb begin
        sum    = {1'b0, in_a} + {1'b0, in_b};
        flag_n = in_result[N-1];
        flag_z = (in_result == '0);
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (in_opcode)
            4'd0: begin
                flag_c = sum[N];
                flag_v = (in_a[N-1] == in_b[N-1]) && (in_result[N-1] != in_a[N-1]);
            end
            4'd1: begin
                flag_c = (in_a < in_b);
                flag_v = (in_a[N-1] != in_b[N-1]) && (in_result[N-1] != in_a[N-1]);
            end
            4'd5: begin
                for (int i = 1; i <= N; i++) begin
                    if (in_b == N'(i)) flag_c = in_a[N-i];
                end
            end
            4'd6, 4'd7: begin
                for (int i = 1; i <= N; i++) begin
                    if (in_b == N'(i)) flag_c = in_a[i-1];
                end
                if (in_opcode == 4'd7 && in_b > N'(N)) flag_c = in_a[N-1];
            end
            default: ;
        endcase
        in_word = {in_result, in_opcode, flag_n, flag_z, flag_c, flag_v};
    end

    assign accept  = in_valid && in_ready_q;
    assign consume = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = in_word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    out_d = in_word;
                end else if (accept) begin
                    skid_d  = in_word;
                    state_d = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Registered ready: no combinational path from out_ready.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_result = out_q[W-1:8];
    assign out_opcode = out_q[7:4];
    assign out_flags  = out_q[3:0];

`ifdef ALU_STATUS_STICKY_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) sticky_d = 1'b0;
        if (consume && out_q[0]) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end

    assign sticky_v = sticky_q;
`endif

endmodule

// File: tb/tb_alu_status_stage.sv
// Self-checking bench for alu_status_stage (N=4): directed cases plus randomized traffic
// checked against a queue-based reference model.

module tb_alu_status_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [3:0] in_opcode = '0;
    logic [3:0] in_result = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic [3:0] out_opcode;
    logic [3:0] out_flags;
    logic       clr_sticky = 1'b0;
`ifdef ALU_STATUS_STICKY_EN
    logic       sticky_v;
`endif

    alu_status_stage #(.N(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_flags  (out_flags)
`ifdef ALU_STATUS_STICKY_EN
        ,
        .clr_sticky (clr_sticky),
        .sticky_v   (sticky_v)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] res;
        logic [3:0] op;
        logic [3:0] fl;
    } word_t;

    word_t q[$];
    logic  sticky_exp = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic int sval(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Reference ALU so that add/sub results are genuine and overflow can be judged arithmetically.
    function automatic logic [3:0] ref_alu(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = (a + b) % 16;
            1: r = (a - b + 16) % 16;
            5: r = (b >= 4) ? 0 : ((a << b) % 16);
            6: r = (b >= 4) ? 0 : (a >> b);
            7: r = (b >= 4) ? ((a >= 8) ? 15 : 0) : ((sval(a) >>> b) & 15);
            default: r = int'($urandom_range(15));
        endcase
        return 4'(r);
    endfunction

    function automatic logic [3:0] ref_flags(input int a, input int b, input int op, input int r);
        int s;
        logic fn, fz, fc, fv;
        fn = (r >= 8);
        fz = (r == 0);
        fc = 1'b0;
        fv = 1'b0;
        case (op)
            0: begin
                fc = (a + b) > 15;
                s  = sval(a) + sval(b);
                fv = (s > 7) || (s < -8);
            end
            1: begin
                fc = a < b;
                s  = sval(a) - sval(b);
                fv = (s > 7) || (s < -8);
            end
            5: fc = (b >= 1 && b <= 4) ? 1'((a >> (4 - b)) & 1) : 1'b0;
            6: fc = (b >= 1 && b <= 4) ? 1'((a >> (b - 1)) & 1) : 1'b0;
            7: begin
                if (b == 0)      fc = 1'b0;
                else if (b <= 4) fc = 1'((a >> (b - 1)) & 1);
                else             fc = 1'((a >> 3) & 1);
            end
            default: ;
        endcase
        return {fn, fz, fc, fv};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, q.size() < 2);
        chk({tag, "_out_valid"}, out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk({tag, "_result"}, out_result, q[0].res);
            chk({tag, "_opcode"}, out_opcode, q[0].op);
            chk({tag, "_flags"}, out_flags, q[0].fl);
        end
`ifdef ALU_STATUS_STICKY_EN
        chk({tag, "_sticky"}, sticky_v, sticky_exp);
`endif
    endtask

    // Called at a falling edge: drives one cycle, advances the model, checks at the next falling edge.
    task automatic cyc(input string tag, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [3:0] r, input logic ordy, input logic clr);
        bit    acc, con;
        word_t w;
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_opcode  = op;
        in_result  = r;
        out_ready  = ordy;
        clr_sticky = clr;
        acc = v && (q.size() < 2);
        con = (q.size() > 0) && ordy;
        @(posedge clk);
        if (clr) sticky_exp = 1'b0;
        if (con && q[0].fl[0]) sticky_exp = 1'b1;
        if (con) void'(q.pop_front());
        if (acc) begin
            w.res = r;
            w.op  = op;
            w.fl  = ref_flags(int'(a), int'(b), int'(op), int'(r));
            q.push_back(w);
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic alu_cyc(input string tag, input logic v, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic ordy);
        cyc(tag, v, a, b, op, ref_alu(int'(a), int'(b), int'(op)), ordy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        sticky_exp = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_result", out_result, 4'd0);
        chk("rst_out_opcode", out_opcode, 4'd0);
        chk("rst_out_flags", out_flags, 4'd0);
`ifdef ALU_STATUS_STICKY_EN
        chk("rst_sticky", sticky_v, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ops [6];
        ops = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd9};

        do_reset();

        // Arithmetic and shift cases with known answers
        alu_cyc("add7p1", 1'b1, 4'd7, 4'd1, 4'd0, 1'b1);
        chk("add7p1_val", out_result, 4'd8);
        chk("add7p1_nzcv", out_flags, 4'b1001);
        alu_cyc("add15p1", 1'b1, 4'd15, 4'd1, 4'd0, 1'b1);
        chk("add15p1_val", out_result, 4'd0);
        chk("add15p1_nzcv", out_flags, 4'b0110);
        alu_cyc("sub3m5", 1'b1, 4'd3, 4'd5, 4'd1, 1'b1);
        chk("sub3m5_val", out_result, 4'd14);
        chk("sub3m5_nzcv", out_flags, 4'b1010);
        alu_cyc("lsl", 1'b1, 4'b1001, 4'd1, 4'd5, 1'b1);
        chk("lsl_val", out_result, 4'b0010);
        chk("lsl_nzcv", out_flags, 4'b0010);
        alu_cyc("asr", 1'b1, 4'b1000, 4'd6, 4'd7, 1'b1);
        chk("asr_val", out_result, 4'b1111);
        chk("asr_nzcv", out_flags, 4'b1010);
        alu_cyc("drain", 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Backpressure: three pass-through words against a stalled sink
        cyc("bp1", 1'b1, 4'd0, 4'd0, 4'd8, 4'd1, 1'b0, 1'b0);
        cyc("bp2", 1'b1, 4'd0, 4'd0, 4'd8, 4'd2, 1'b0, 1'b0);
        chk("bp_full_ready", in_ready, 1'b0);
        cyc("bp3", 1'b1, 4'd0, 4'd0, 4'd8, 4'd3, 1'b0, 1'b0);
        chk("bp_hold_ready", in_ready, 1'b0);
        chk("bp_hold_out", out_result, 4'd1);
        cyc("bp4", 1'b1, 4'd0, 4'd0, 4'd8, 4'd3, 1'b1, 1'b0);
        chk("bp_seq2", out_result, 4'd2);
        chk("bp_ready_back", in_ready, 1'b1);
        cyc("bp5", 1'b1, 4'd0, 4'd0, 4'd8, 4'd3, 1'b1, 1'b0);
        chk("bp_seq3", out_result, 4'd3);
        cyc("bp6", 1'b0, 4'd0, 4'd0, 4'd8, 4'd0, 1'b1, 1'b0);
        chk("bp_empty", out_valid, 1'b0);

        // Reset while FULL, then one word through with single-cycle latency
        cyc("fill1", 1'b1, 4'd1, 4'd2, 4'd0, 4'd3, 1'b0, 1'b0);
        cyc("fill2", 1'b1, 4'd0, 4'd0, 4'd11, 4'd6, 1'b0, 1'b0);
        chk("fill_full", in_ready, 1'b0);
        do_reset();
        check_outputs("post_rst");
        alu_cyc("post_rst_word", 1'b1, 4'd2, 4'd3, 4'd0, 1'b0);
        chk("post_rst_val", out_result, 4'd5);
        alu_cyc("post_rst_drain", 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);

`ifdef ALU_STATUS_STICKY_EN
        alu_cyc("stk_add", 1'b1, 4'd7, 4'd1, 4'd0, 1'b0);
        chk("stk_not_yet", sticky_v, 1'b0);
        alu_cyc("stk_consume", 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("stk_set", sticky_v, 1'b1);
        cyc("stk_clr", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        chk("stk_cleared", sticky_v, 1'b0);
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            op = ops[$urandom_range(5)];
            if (op == 4'd9) op = 4'($urandom_range(15));
            cyc_rand: begin
                logic [3:0] a, b;
                a = 4'($urandom_range(15));
                b = (op >= 4'd5 && op <= 4'd7) ? 4'($urandom_range(7)) : 4'($urandom_range(15));
                cyc("rnd", ($urandom_range(9) < 7), a, b, op, ref_alu(int'(a), int'(b), int'(op)),
                    ($urandom_range(9) < 6), ($urandom_range(9) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
